tx_ffe: RTL
===========

# tx_ffe

Transmit-side 3-tap feed-forward equalizer (pre-cursor / main / post-cursor) for the SerDes TX path. It maps the serialized NRZ bit stream to signed fixed-point drive levels, pre-distorting each symbol so that the channel plus the receiver CTLE sees an opened eye. Tap coefficients are reprogrammable at run time through a shadowed, handshaked update port, and each update is applied only on a symbol boundary.

## Interface
- COEF_W, 6: signed tap width (two's complement).
- OUT_W, 8: signed output width. OUT_W ≥ 2 is required.
- PRE_DEF, -4: pre-cursor tap value at reset.
- MAIN_DEF, 24: main tap value at reset.
- POST_DEF, -8: post-cursor tap value at reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_in  in  1  serialized data bit; 1 maps to +1 and 0 maps to −1.
- bit_valid  in  1  bit_in is accepted on every cycle this is high. There is no backpressure.
- coef_wr  in  1  single-cycle request to load new tap values.
- coef_pre, coef_main, coef_post  in  COEF_W each  new tap values, sampled when coef_wr is high.
- coef_ack  out  1  one-cycle pulse when the pending taps become active.
- ffe_out  out  OUT_W  signed equalized sample.
- ffe_valid  out  1  ffe_out is valid this cycle.
- sat_flag  out  1  the current ffe_out was clipped; qualified by ffe_valid.

## Operation
- Window: three symbols s[k], s[k−1], s[k−2]. s[k] is the newest bit accepted.
- Output for symbol s[k−1]: y = c_pre·s[k] + c_main·s[k−1] + c_post·s[k−2].
  - Each multiply by ±1 is a conditional negate; no multipliers are used.
  - Sum width is COEF_W+2 bits.
  - The result is saturated to the OUT_W signed range [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - sat_flag is 1 when saturation occurred.
- State machine:
  - FILL0: no bits held. A bit_valid moves to FILL1.
  - FILL1: one bit held. A bit_valid moves to RUN.
  - RUN: every bit_valid produces one output. RUN stays in RUN.
  - Reset is the only way back to FILL0.
- Gaps (bit_valid low) leave the window frozen. The state is unchanged and ffe_valid is 0 in the following cycle.
- Coefficient shadowing:
  - coef_wr writes the values into a pending register and sets the pending flag.
  - On the clock edge of a cycle with bit_valid high and pending set:
    - the active taps take the pending values;
    - the pending flag is cleared;
    - coef_ack is high in the following cycle.
  - The output computed in that same cycle uses the old taps.
  - coef_wr while an update is already pending overwrites it. Only the last write is applied, with one ack.
  - coef_wr in the same cycle as bit_valid with nothing pending: the values are captured only and applied at the next bit_valid.
  - coef_wr and apply in the same cycle: the new write wins. pending stays set, the earlier pending values become active, and coef_ack pulses for that apply.
  - Coefficient updates apply in FILL states as well.

## Timing
- Latency: the accept of bit b_k (cycle t) gives ffe_valid=1 and ffe_out = y for symbol b_{k−1} at cycle t+1.
- ffe_out, ffe_valid and sat_flag are registered.
- Throughput: one output per accepted bit, up to 1 per cycle.
- Reset values:
  - ffe_out=0, ffe_valid=0, sat_flag=0, coef_ack=0.
  - State FILL0, window cleared, pending flag clear.
  - Active taps = PRE_DEF/MAIN_DEF/POST_DEF.
- Reset mid-stream: every output drops on the rst_n edge. The first output after release needs three fresh bits.

## Structure
- Package `serdes_ffe_pkg`:
  - COEF_W default;
  - `coef_t` typedef;
  - `ffe_state_e` enum (FILL0, FILL1, RUN);
  - `sat_sum` function (width-generic clip returning value and flag).
- Sub-module `ffe_coef_shadow`: the pending/active tap registers, the pending flag and coef_ack generation. The top level holds the window, the FSM and the datapath.

## Test plan
- Defaults; bits 0,1,1,0 on consecutive cycles → no output for the first two. Then ffe_out=28, then 20, with ffe_valid on the cycles after bits 3 and 4; sat_flag=0.
- Continuous 1s after fill → steady ffe_out=12. Continuous 0s → −12.
- bit_valid gaps: bits 0,1 then 3 idle cycles, then 1 → single output 28, with ffe_valid low during the gap.
- Write pre=0, main=31, post=0 while in RUN, with bit_valid high in the same cycle → the next output still uses the defaults. coef_ack pulses one cycle after the following bit_valid; later outputs are ±31.
- Two coef_wr before any bit_valid (main=10, then main=20) → a single coef_ack; main=20 is active.
- OUT_W=7 instance with pre=−32, main=31, post=−32 and pattern 0,1,0 → ffe_out=63, sat_flag=1. Assert rst_n mid-stream → outputs 0 immediately and the FSM refills.

Source files
------------

// File: rtl/serdes_ffe_pkg.sv
// Shared types and helpers for the transmit-side feed-forward equalizer.
//   CoefWDef    : default signed tap width
//   coef_t      : signed tap at the default width
//   ffe_state_e : window fill state (two FILL states, then RUN)
//   sat_sum     : clip a signed sum to an arbitrary signed output width
package serdes_ffe_pkg;

  localparam int unsigned CoefWDef = 6;

  typedef logic signed [CoefWDef-1:0] coef_t;

  typedef enum logic [1:0] {
    StFill0 = 2'd0,
    StFill1 = 2'd1,
    StRun   = 2'd2
  } ffe_state_e;

  typedef struct packed {
    logic signed [31:0] value;
    logic               sat;
  } sat_res_t;

  // Clip sum into [-2^(out_w-1), 2^(out_w-1)-1]; sat reports whether clipping happened.
  function automatic sat_res_t sat_sum(input int sum, input int unsigned out_w);
    sat_res_t res;
    int       hi;
    int       lo;
    hi        = (1 <<< (out_w - 1)) - 1;
    lo        = -hi - 1;
    res.value = sum;
    res.sat   = 1'b0;
    if (sum > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (sum < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ffe_coef_shadow.sv
// Shadowed tap registers for the FFE.
// A write lands in a pending set; the pending set is copied into the active taps on the
// next symbol boundary (apply_i high while something is pending), with a one-cycle ack.
//   clk_i, rst_ni           : clock, async active-low reset
//   wr_i, wr_*_i            : tap write request and new tap values
//   apply_i                 : symbol boundary (a bit is accepted this cycle)
//   pre_o, main_o, post_o   : active taps
//   ack_o                   : pulses the cycle after pending taps become active
module ffe_coef_shadow
  import serdes_ffe_pkg::*;
#(
  parameter int unsigned COEF_W   = CoefWDef,
  parameter int          PRE_DEF  = -4,
  parameter int          MAIN_DEF = 24,
  parameter int          POST_DEF = -8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_i,
  input  logic signed [COEF_W-1:0] wr_pre_i,
  input  logic signed [COEF_W-1:0] wr_main_i,
  input  logic signed [COEF_W-1:0] wr_post_i,
  input  logic                     apply_i,
  output logic signed [COEF_W-1:0] pre_o,
  output logic signed [COEF_W-1:0] main_o,
  output logic signed [COEF_W-1:0] post_o,
  output logic                     ack_o
);

  localparam logic signed [COEF_W-1:0] PreRst  = COEF_W'(PRE_DEF);
  localparam logic signed [COEF_W-1:0] MainRst = COEF_W'(MAIN_DEF);
  localparam logic signed [COEF_W-1:0] PostRst = COEF_W'(POST_DEF);

  logic signed [COEF_W-1:0] pend_pre_q, pend_pre_d;
  logic signed [COEF_W-1:0] pend_main_q, pend_main_d;
  logic signed [COEF_W-1:0] pend_post_q, pend_post_d;
  logic signed [COEF_W-1:0] act_pre_q, act_pre_d;
  logic signed [COEF_W-1:0] act_main_q, act_main_d;
  logic signed [COEF_W-1:0] act_post_q, act_post_d;
  logic                     pend_q, pend_d;
  logic                     ack_q, ack_d;
  logic                     apply;

  always_comb begin
    pend_pre_d  = pend_pre_q;
    pend_main_d = pend_main_q;
    pend_post_d = pend_post_q;
    act_pre_d   = act_pre_q;
    act_main_d  = act_main_q;
    act_post_d  = act_post_q;
    pend_d      = pend_q;
    apply       = apply_i & pend_q;
    ack_d       = apply;

    if (apply) begin
      act_pre_d  = pend_pre_q;
      act_main_d = pend_main_q;
      act_post_d = pend_post_q;
      pend_d     = 1'b0;
    end

    // A write in the same cycle as an apply re-arms pending with the new values,
    // while the previously pending values are the ones that go active.
    if (wr_i) begin
      pend_pre_d  = wr_pre_i;
      pend_main_d = wr_main_i;
      pend_post_d = wr_post_i;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_pre_q  <= PreRst;
      pend_main_q <= MainRst;
      pend_post_q <= PostRst;
      act_pre_q   <= PreRst;
      act_main_q  <= MainRst;
      act_post_q  <= PostRst;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      pend_pre_q  <= pend_pre_d;
      pend_main_q <= pend_main_d;
      pend_post_q <= pend_post_d;
      act_pre_q   <= act_pre_d;
      act_main_q  <= act_main_d;
      act_post_q  <= act_post_d;
      pend_q      <= pend_d;
      ack_q       <= ack_d;
    end
  end

  assign pre_o  = act_pre_q;
  assign main_o = act_main_q;
  assign post_o = act_post_q;
  assign ack_o  = ack_q;

endmodule

// File: rtl/tx_ffe.sv
// Transmit 3-tap feed-forward equalizer (pre / main / post cursor).
// Maps NRZ bits (1 -> +1, 0 -> -1) to y = c_pre*s[k] + c_main*s[k-1] + c_post*s[k-2],
// saturated to OUT_W signed bits (OUT_W must be at least 2). One output per accepted bit
// once two bits are held; output registered one cycle after the accept.
//   clk, rst_n                    : clock, async active-low reset
//   bit_in, bit_valid             : serialized data bit and its qualifier (no backpressure)
//   coef_wr, coef_pre/main/post   : tap update request and values
//   coef_ack                      : pulse when the requested taps became active
//   ffe_out, ffe_valid, sat_flag  : equalized sample, its valid, and clip indication
module tx_ffe
  import serdes_ffe_pkg::*;
#(
  parameter int unsigned COEF_W   = CoefWDef,
  parameter int unsigned OUT_W    = 8,
  parameter int          PRE_DEF  = -4,
  parameter int          MAIN_DEF = 24,
  parameter int          POST_DEF = -8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     coef_wr,
  input  logic signed [COEF_W-1:0] coef_pre,
  input  logic signed [COEF_W-1:0] coef_main,
  input  logic signed [COEF_W-1:0] coef_post,
  output logic                     coef_ack,
  output logic signed [OUT_W-1:0]  ffe_out,
  output logic                     ffe_valid,
  output logic                     sat_flag
);

  // Three taps of COEF_W bits, each negated: two extra bits hold any sum without wrap.
  localparam int unsigned SumW = COEF_W + 2;

  logic signed [COEF_W-1:0] act_pre, act_main, act_post;

  ffe_coef_shadow #(
    .COEF_W  (COEF_W),
    .PRE_DEF (PRE_DEF),
    .MAIN_DEF(MAIN_DEF),
    .POST_DEF(POST_DEF)
  ) u_coef_shadow (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wr_i     (coef_wr),
    .wr_pre_i (coef_pre),
    .wr_main_i(coef_main),
    .wr_post_i(coef_post),
    .apply_i  (bit_valid),
    .pre_o    (act_pre),
    .main_o   (act_main),
    .post_o   (act_post),
    .ack_o    (coef_ack)
  );

  // Window: s1 is s[k-1] (newest held bit), s2 is s[k-2].
  ffe_state_e              state_q, state_d;
  logic                    s1_q, s1_d;
  logic                    s2_q, s2_d;
  logic signed [OUT_W-1:0] ffe_out_q, ffe_out_d;
  logic                    ffe_valid_q, ffe_valid_d;
  logic                    sat_q, sat_d;

  logic signed [SumW-1:0]  pre_x, main_x, post_x;
  logic signed [SumW-1:0]  term_pre, term_main, term_post;
  logic signed [SumW-1:0]  sum;
  sat_res_t                sat_r;

  // Datapath: sign-extend before negating so the most negative tap cannot overflow.
  always_comb begin
    pre_x     = SumW'(act_pre);
    main_x    = SumW'(act_main);
    post_x    = SumW'(act_post);
    term_pre  = bit_in ? pre_x : -pre_x;
    term_main = s1_q ? main_x : -main_x;
    term_post = s2_q ? post_x : -post_x;
    sum       = term_pre + term_main + term_post;
    sat_r     = sat_sum(int'(sum), OUT_W);
  end

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    ffe_valid_d = 1'b0;
    ffe_out_d   = ffe_out_q;
    sat_d       = sat_q;
    if (bit_valid) begin
      s1_d = bit_in;
      s2_d = s1_q;
      unique case (state_q)
        StFill0: state_d = StFill1;
        StFill1: state_d = StRun;
        StRun: begin
          ffe_valid_d = 1'b1;
          ffe_out_d   = OUT_W'(sat_r.value);
          sat_d       = sat_r.sat;
        end
        default: state_d = StFill0;
      endcase
    end
  end

  // FSM, window and registered outputs share one sequential block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      ffe_out_q   <= '0;
      ffe_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      ffe_out_q   <= ffe_out_d;
      ffe_valid_q <= ffe_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign ffe_out   = ffe_out_q;
  assign ffe_valid = ffe_valid_q;
  assign sat_flag  = sat_q;

endmodule
